// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
//
// Round-robin arbiter that shares the write port of one occupancy-counted
// AXI-stream FIFO between N_SRC upstream AXI-stream sources. Each grant is a
// burst of up to BURST words from one source. A burst is only started when the
// FIFO occupancy shows room for the whole burst, so the FIFO cannot overflow.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            asynchronous, active-low reset
//   en             arbitration enable; blocks new grants only
//   s_axis_*       N_SRC source streams, source i at [i*WIDTH +: WIDTH]
//   m_axis_*       stream into the FIFO slave port
//   fifo_count     FIFO occupancy in words
//   grant_valid    a burst is in progress
//   grant_idx      index of the granted source
//   beats_total    accepted beats, wraps modulo 2^32
//   abort_count    bursts ended by timeout, saturating

module fifo_rr_arbiter #(
  parameter int WIDTH   = 16,
  parameter int N_SRC   = 4,
  parameter int BURST   = 8,
  parameter int DEPTH   = 65536,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_SRC*WIDTH-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]       s_axis_tvalid,
  output logic [N_SRC-1:0]       s_axis_tready,
  output logic [WIDTH-1:0]       m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  input  logic [31:0]            fifo_count,
  output logic                   grant_valid,
  output logic [2:0]             grant_idx,
  output logic [31:0]            beats_total,
  output logic [15:0]            abort_count
);

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  last_idx;
  logic [7:0]  beat_cnt;
  logic [15:0] idle_cnt;

  logic [32:0] space_need;
  logic        room;
  logic        pick_found;
  logic [2:0]  pick_idx;
  logic        handshake;
  logic        last_beat;
  logic        timed_out;

  // Room check in 33 bits so a near-full 32-bit count plus BURST cannot wrap
  // around and look small.
  assign space_need = {1'b0, fifo_count} + 33'(BURST);
  assign room       = (space_need <= 33'(DEPTH));

  // Rotating priority: scan last_idx+1, last_idx+2, ... and take the first
  // requester. The nested loop compares against the loop constant instead of
  // indexing with a computed value.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!pick_found && s_axis_tvalid[i] &&
            (i == ((int'(last_idx) + k) % N_SRC))) begin
          pick_found = 1'b1;
          pick_idx   = 3'(i);
        end
      end
    end
  end

  // Zero-latency data/valid/ready mux. Only the granted source sees tready;
  // everything is quiet in IDLE.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (state == ST_BURST && grant_idx == 3'(i)) begin
        m_axis_tdata     = s_axis_tdata[i*WIDTH +: WIDTH];
        m_axis_tvalid    = s_axis_tvalid[i];
        s_axis_tready[i] = m_axis_tready;
      end
    end
  end

  assign handshake    = m_axis_tvalid & m_axis_tready;
  assign last_beat    = (state == ST_BURST) && (beat_cnt == 8'(BURST - 1));
  assign m_axis_tlast = last_beat;
  assign timed_out    = (state == ST_BURST) && !handshake &&
                        (idle_cnt == 16'(TIMEOUT - 1));
  assign grant_valid  = (state == ST_BURST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (en && pick_found && room) begin
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if ((handshake && last_beat) || timed_out) begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // last_idx starts at N_SRC-1 so source 0 is first after reset. It is only
  // updated when a burst ends, so a reset mid-burst forgets the partial grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      grant_idx   <= '0;
      last_idx    <= 3'(N_SRC - 1);
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      beats_total <= '0;
      abort_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (state_nxt == ST_BURST) begin
            grant_idx <= pick_idx;
            beat_cnt  <= '0;
            idle_cnt  <= '0;
          end
        end
        ST_BURST: begin
          if (handshake) begin
            beat_cnt    <= beat_cnt + 8'd1;
            beats_total <= beats_total + 32'd1;
            idle_cnt    <= '0;
            if (last_beat) begin
              last_idx <= grant_idx;
            end
          end else if (timed_out) begin
            last_idx <= grant_idx;
            if (abort_count != 16'hFFFF) begin
              abort_count <= abort_count + 16'd1;
            end
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule
